// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
//   DEF_HALF_50M_5HZ : half-period giving 5 Hz from a 50 MHz clock
//   HALF_50M_1HZ     : half-period giving 1 Hz from a 50 MHz clock
//   calc_half()      : half-period in input-clock cycles for a given f_in/f_out
package clk_div_pkg;

  localparam int unsigned DEF_HALF_50M_5HZ = 5_000_000;
  localparam int unsigned HALF_50M_1HZ     = 25_000_000;

  // A zero output frequency maps to a zero half-period, which stops a channel.
  function automatic int unsigned calc_half(input int unsigned f_in,
                                            input int unsigned f_out);
    if (f_out == 0) return 0;
    return f_in / (2 * f_out);
  endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Divisor load port for clk_div_multi.
//   Ld_Valid : load request strobe, sampled every clock edge
//   Ld_Ch    : target channel index
//   Ld_Half  : new half-period in system clock cycles
//   Ld_Ack   : one-cycle acknowledge of an accepted load
//   Ld_Err   : one-cycle flag for a load aimed at a missing channel
interface clk_div_multi_if #(
  parameter int IDX_W = 2,
  parameter int CNT_W = 23
);
  logic             Ld_Valid;
  logic [IDX_W-1:0] Ld_Ch;
  logic [CNT_W-1:0] Ld_Half;
  logic             Ld_Ack;
  logic             Ld_Err;

  modport master (output Ld_Valid, Ld_Ch, Ld_Half, input Ld_Ack, Ld_Err);
  modport slave  (input Ld_Valid, Ld_Ch, Ld_Half, output Ld_Ack, Ld_Err);
endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: half-period counter, active/pending divisor and the
// registered square-wave and tick outputs.
//   Clk, Rst : system clock, async active-high reset
//   En       : run enable
//   Ld       : decoded load strobe for this channel
//   Ld_Half  : half-period carried by the load
//   ClkOut   : divided square wave (period 2*half_act)
//   Tick     : one-cycle pulse on every ClkOut toggle
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int          CNT_W    = 23,
  parameter int unsigned DEF_HALF = DEF_HALF_50M_5HZ
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic             Ld,
  input  logic [CNT_W-1:0] Ld_Half,
  output logic             ClkOut,
  output logic             Tick
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_HALF);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] half_act;
  logic [CNT_W-1:0] half_pend;
  logic             pend_v;
  logic             run;
  logic             wrap;
  logic             apply;

  // A zero divisor behaves exactly like a disabled channel. A pending value
  // is only promoted at a wrap (or at once while stopped) so the square wave
  // never sees a truncated half. A load landing on the same edge wins over
  // the older pending value, which is therefore not promoted.
  always_comb begin
    run   = En && (half_act != '0);
    wrap  = run && (cnt == half_act);
    apply = pend_v && !Ld && (!run || wrap);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt       <= ONE;
      half_act  <= DEF;
      half_pend <= DEF;
      pend_v    <= 1'b0;
      ClkOut    <= 1'b0;
      Tick      <= 1'b0;
    end else begin
      if (!run) begin
        cnt    <= ONE;
        ClkOut <= 1'b0;
        Tick   <= 1'b0;
      end else if (wrap) begin
        cnt    <= ONE;
        ClkOut <= ~ClkOut;
        Tick   <= 1'b1;
      end else begin
        cnt    <= cnt + ONE;
        Tick   <= 1'b0;
      end

      if (Ld) begin
        half_pend <= Ld_Half;
        pend_v    <= 1'b1;
      end else if (apply) begin
        half_act  <= half_pend;
        pend_v    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// NUM_CH independent clock dividers sharing one system clock, with a common
// runtime divisor load port.
//   Clk, Rst : system clock, async active-high reset
//   En       : per-channel run enable
//   ld       : divisor load port (slave side)
//   ClkOut   : per-channel divided square waves
//   Tick     : per-channel one-cycle pulse on each ClkOut toggle
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int          NUM_CH   = 4,
  parameter int          CNT_W    = 23,
  parameter int unsigned DEF_HALF = DEF_HALF_50M_5HZ,
  parameter int          IDX_W    = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [NUM_CH-1:0] En,
  clk_div_multi_if.slave    ld,
  output logic [NUM_CH-1:0] ClkOut,
  output logic [NUM_CH-1:0] Tick
);

  logic [IDX_W-1:0]  ld_ch;
  logic              ch_ok;
  logic [NUM_CH-1:0] ld_dec;

  assign ld_ch = ld.Ld_Ch;

  // Indices at or above NUM_CH are rejected rather than aliased onto a
  // real channel.
  always_comb begin
    ch_ok  = (int'(ld_ch) < NUM_CH);
    ld_dec = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ld_dec[i] = ld.Ld_Valid && (int'(ld_ch) == i);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ld.Ld_Ack <= 1'b0;
      ld.Ld_Err <= 1'b0;
    end else begin
      ld.Ld_Ack <= ld.Ld_Valid && ch_ok;
      ld.Ld_Err <= ld.Ld_Valid && !ch_ok;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_ch #(
      .CNT_W    (CNT_W),
      .DEF_HALF (DEF_HALF)
    ) u_ch (
      .Clk     (Clk),
      .Rst     (Rst),
      .En      (En[g]),
      .Ld      (ld_dec[g]),
      .Ld_Half (ld.Ld_Half),
      .ClkOut  (ClkOut[g]),
      .Tick    (Tick[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
module tb_clk_div_multi;

  localparam int NCH = 2;
  localparam int CW  = 8;
  localparam int IW  = 2;
  localparam int DH  = 3;

  logic           Clk = 1'b0;
  logic           Rst;
  logic [NCH-1:0] En;
  logic [NCH-1:0] ClkOut;
  logic [NCH-1:0] Tick;

  clk_div_multi_if #(.IDX_W(IW), .CNT_W(CW)) ld_if ();

  clk_div_multi #(
    .NUM_CH   (NCH),
    .CNT_W    (CW),
    .DEF_HALF (DH),
    .IDX_W    (IW)
  ) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .En     (En),
    .ld     (ld_if),
    .ClkOut (ClkOut),
    .Tick   (Tick)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [NCH-1:0] co;
    logic [NCH-1:0] tk;
    logic           ack;
    logic           err;
  } exp_t;

  typedef struct {
    int   ch;
    int   half;
    logic ack;
    logic err;
  } vec_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_tick[NCH];
  int   prev_tick[NCH];

  int   m_cnt[NCH];
  int   m_act[NCH];
  int   m_pend[NCH];
  bit   m_pv[NCH];
  bit   m_out[NCH];
  bit   m_tick[NCH];

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, got, want);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_cnt[c] = 1; m_act[c] = DH; m_pend[c] = DH;
      m_pv[c] = 0; m_out[c] = 0; m_tick[c] = 0;
    end
  endtask

  // Reference behaviour for the next edge, queued before the edge happens.
  task automatic model_step();
    exp_t e;
    int   lch;
    bit   ldh, stopped, wrapped;
    e = '0;
    lch = int'(ld_if.Ld_Ch);
    if (Rst) begin
      model_reset();
    end else begin
      for (int c = 0; c < NCH; c++) begin
        ldh     = ld_if.Ld_Valid && (lch == c);
        stopped = !En[c] || (m_act[c] == 0);
        wrapped = !stopped && (m_cnt[c] == m_act[c]);
        if (stopped) begin
          m_cnt[c] = 1; m_out[c] = 0; m_tick[c] = 0;
        end else if (wrapped) begin
          m_cnt[c] = 1; m_out[c] = !m_out[c]; m_tick[c] = 1;
        end else begin
          m_cnt[c] = m_cnt[c] + 1; m_tick[c] = 0;
        end
        if ((stopped || wrapped) && m_pv[c] && !ldh) begin
          m_act[c] = m_pend[c]; m_pv[c] = 0;
        end
        if (ldh) begin
          m_pend[c] = int'(ld_if.Ld_Half); m_pv[c] = 1;
        end
        e.co[c] = m_out[c];
        e.tk[c] = m_tick[c];
      end
      e.ack = ld_if.Ld_Valid && (lch < NCH);
      e.err = ld_if.Ld_Valid && (lch >= NCH);
    end
    sbq.push_back(e);
  endtask

  task automatic cycle();
    exp_t e, g;
    model_step();
    @(posedge Clk);
    #1;
    cyc++;
    e = sbq.pop_front();
    g = {ClkOut, Tick, ld_if.Ld_Ack, ld_if.Ld_Err};
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL sb cyc=%0d got co=%b tk=%b ack=%b err=%b want co=%b tk=%b ack=%b err=%b",
               cyc, g.co, g.tk, g.ack, g.err, e.co, e.tk, e.ack, e.err);
    end
    for (int c = 0; c < NCH; c++) begin
      if (Tick[c]) begin
        prev_tick[c] = last_tick[c];
        last_tick[c] = cyc;
      end
    end
  endtask

  // Runs until the channel ticks; returns the length of the half just ended.
  task automatic wait_tick(input int c, output int half);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!Tick[c] && n < 60);
    if (!Tick[c]) chk("tick_timeout", 0, 1);
    half = last_tick[c] - prev_tick[c];
  endtask

  task automatic load(input int c, input int h);
    ld_if.Ld_Valid = 1'b1;
    ld_if.Ld_Ch    = IW'(c);
    ld_if.Ld_Half  = CW'(h);
  endtask

  task automatic mark_release();
    for (int c = 0; c < NCH; c++) begin
      last_tick[c] = cyc;
      prev_tick[c] = cyc;
    end
  endtask

  initial begin
    vec_t vecs[5];
    int   h, bad, cl;

    vecs[0] = '{ch: 0, half: 6, ack: 1'b1, err: 1'b0};
    vecs[1] = '{ch: 0, half: 4, ack: 1'b1, err: 1'b0};
    vecs[2] = '{ch: 1, half: 5, ack: 1'b1, err: 1'b0};
    vecs[3] = '{ch: 3, half: 7, ack: 1'b0, err: 1'b1};
    vecs[4] = '{ch: 2, half: 7, ack: 1'b0, err: 1'b1};

    Rst = 1'b1;
    En  = '0;
    ld_if.Ld_Valid = 1'b0;
    ld_if.Ld_Ch    = '0;
    ld_if.Ld_Half  = '0;
    model_reset();
    #1;
    chk("rst_clkout", int'(ClkOut), 0);
    chk("rst_tick", int'(Tick), 0);
    chk("rst_ackerr", int'({ld_if.Ld_Ack, ld_if.Ld_Err}), 0);
    En = '1;
    cycle();
    cycle();
    chk("rst_hold_clkout", int'(ClkOut), 0);

    // Reset default: half of 3, both channels in step.
    Rst = 1'b0;
    mark_release();
    wait_tick(0, h); chk("def_half0_a", h, 3);
    chk("def_rise0", int'(ClkOut[0]), 1);
    chk("def_rise1", int'(ClkOut[1]), 1);
    wait_tick(0, h); chk("def_half0_b", h, 3);
    chk("def_fall0", int'(ClkOut[0]), 0);

    // Runtime load of ch1 mid-period.
    cycle();
    load(1, 5);
    cycle();
    ld_if.Ld_Valid = 1'b0;
    chk("load_ack", int'(ld_if.Ld_Ack), 1);
    wait_tick(1, h); chk("load_old_half", h, 3);
    wait_tick(1, h); chk("load_new_half_a", h, 5);
    wait_tick(1, h); chk("load_new_half_b", h, 5);
    wait_tick(0, h); chk("load_ch0_unaffected", h, 3);

    // Collision: load ch0 on its own toggle edge.
    wait_tick(0, h);
    cycle();
    cycle();
    load(0, 2);
    cycle();
    ld_if.Ld_Valid = 1'b0;
    chk("coll_tick", int'(Tick[0]), 1);
    chk("coll_half", last_tick[0] - prev_tick[0], 3);
    wait_tick(0, h); chk("coll_next_half", h, 3);
    wait_tick(0, h); chk("coll_new_half_a", h, 2);
    wait_tick(0, h); chk("coll_new_half_b", h, 2);

    // Disable ch0 for 10 cycles, loading a zero divisor meanwhile.
    En[0] = 1'b0;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) load(0, 0);
      cycle();
      ld_if.Ld_Valid = 1'b0;
      if (ClkOut[0] || Tick[0]) bad++;
    end
    chk("dis_quiet", bad, 0);
    En[0] = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (ClkOut[0] || Tick[0]) bad++;
    end
    chk("zero_div_quiet", bad, 0);
    load(0, 4);
    cycle();
    ld_if.Ld_Valid = 1'b0;
    cl = cyc;
    wait_tick(0, h);
    chk("reen_first_rise", cyc - cl, 5);
    chk("reen_level", int'(ClkOut[0]), 1);

    // Table of loads: last-wins on ch0, then two out-of-range indices.
    for (int v = 0; v < 5; v++) begin
      load(vecs[v].ch, vecs[v].half);
      cycle();
      chk($sformatf("vec%0d_ack", v), int'(ld_if.Ld_Ack), int'(vecs[v].ack));
      chk($sformatf("vec%0d_err", v), int'(ld_if.Ld_Err), int'(vecs[v].err));
    end
    ld_if.Ld_Valid = 1'b0;
    cycle();
    chk("vec_idle_ackerr", int'({ld_if.Ld_Ack, ld_if.Ld_Err}), 0);
    wait_tick(0, h);
    wait_tick(0, h);
    wait_tick(0, h); chk("vec_ch0_half", h, 4);
    wait_tick(1, h);
    wait_tick(1, h);
    wait_tick(1, h); chk("vec_ch1_half", h, 5);

    // Async reset while ch1 is high with a load pending.
    wait_tick(1, h);
    if (!ClkOut[1]) wait_tick(1, h);
    chk("pre_rst_high", int'(ClkOut[1]), 1);
    load(1, 2);
    cycle();
    ld_if.Ld_Valid = 1'b0;
    #2;
    Rst = 1'b1;
    #1;
    chk("async_rst_clkout", int'(ClkOut), 0);
    chk("async_rst_tick", int'(Tick), 0);
    model_reset();
    cycle();
    cycle();
    Rst = 1'b0;
    mark_release();
    wait_tick(1, h); chk("post_rst_half_a", h, 3);
    chk("post_rst_rise", int'(ClkOut[1]), 1);
    wait_tick(1, h); chk("post_rst_half_b", h, 3);
    wait_tick(0, h); chk("post_rst_ch0", h, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
